sbox_share_sched: RTL

- Time-multiplexes one shared 2-share threshold S-box core between two requesters: state-byte SubBytes (ST) and the key-schedule SubWord (KS).
- Accepts share pairs over valid/ready handshakes, gates each issue on fresh randomness, and tags each issue.
- Tracks the core's fixed-latency pipeline and returns results to the correct requester with the original tag.
- Sits between the round controller / key expansion and the S-box core (basis-change map, inversion stages, output map).

---
 rtl/sbox_share_sched_pkg.sv | 33 +++
 rtl/sbox_share_sched_tag_pipe.sv | 52 +++++
 rtl/sbox_share_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sbox_share_sched_pkg.sv
// Shared definitions for the S-box share scheduler.
//   - Requester encodings (DST_ST / DST_KS) used on res_dst and in the
//     in-flight tracking entries.
//   - Tag widths for each requester and for the result side.
//   - Default pass sizes and result counter widths.
//   - inflight_t: one entry of the in-flight tracking pipe.
package sbox_share_sched_pkg;

  localparam logic DST_ST = 1'b0;
  localparam logic DST_KS = 1'b1;

  localparam int ST_TAG_W  = 4;
  localparam int KS_TAG_W  = 2;
  localparam int RES_TAG_W = 4;

  localparam int ST_BYTES_DEF = 16;
  localparam int KS_BYTES_DEF = 4;

  localparam int ST_CNT_W = 5;
  localparam int KS_CNT_W = 3;

  typedef struct packed {
    logic                 valid;
    logic                 dst;
    logic [RES_TAG_W-1:0] tag;
  } inflight_t;

  // KS tags travel on the wider result tag bus, zero-extended.
  function automatic logic [RES_TAG_W-1:0] ks_tag_ext(input logic [KS_TAG_W-1:0] t);
    return {{(RES_TAG_W-KS_TAG_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/sbox_share_sched_tag_pipe.sv
// In-flight tracking pipe for the shared S-box core.
//   clk, rst    : clock, synchronous active-high reset
//   in_entry    : entry written on an issue cycle (all-zero when idle)
//   tail_valid  : tail entry valid; aligned with the core's output shares
//   tail_dst    : tail entry requester
//   out_entry   : tail delayed one cycle, aligned with the registered result
//   busy        : any valid entry in the pipe or the output stage
// The pipe is SBOX_LAT deep so an entry reaches the tail in exactly the
// cycle the core presents the matching result.
module sbox_share_sched_tag_pipe
  import sbox_share_sched_pkg::*;
#(
  parameter int SBOX_LAT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  inflight_t in_entry,
  output logic      tail_valid,
  output logic      tail_dst,
  output inflight_t out_entry,
  output logic      busy
);

  inflight_t           stage_reg [SBOX_LAT];
  inflight_t           out_reg;
  logic [SBOX_LAT-1:0] stage_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) begin
        stage_reg[i] <= '0;
      end
      out_reg <= '0;
    end else begin
      stage_reg[0] <= in_entry;
      for (int i = 1; i < SBOX_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      out_reg <= stage_reg[SBOX_LAT-1];
    end
  end

  for (genvar gi = 0; gi < SBOX_LAT; gi++) begin : g_valid
    assign stage_valid[gi] = stage_reg[gi].valid;
  end

  assign tail_valid = stage_reg[SBOX_LAT-1].valid;
  assign tail_dst   = stage_reg[SBOX_LAT-1].dst;
  assign out_entry  = out_reg;
  assign busy       = (|stage_valid) | out_reg.valid;

endmodule

// File: rtl/sbox_share_sched.sv
// Scheduler sharing one 2-share threshold S-box core between the state
// SubBytes requester (ST) and the key-schedule SubWord requester (KS).
//   clk, rst                 : clock, synchronous active-high reset
//   st_valid/st_ready        : ST handshake; st_s0/st_s1 shares, st_tag index
//   ks_valid/ks_ready        : KS handshake; ks_s0/ks_s1 shares, ks_tag index
//   rnd_valid/rnd/rnd_take   : fresh randomness, consumed on every issue
//   core_en/core_s0/core_s1/core_rnd : issue to the core (zero when idle)
//   core_o0/core_o1          : core result shares, SBOX_LAT cycles after core_en
//   res_valid/res_dst/res_tag/res_s0/res_s1 : registered result stream
//   st_done/ks_done          : pulse with the last result of a pass
//   busy                     : any issue still in flight
// Shares are only ever routed, never combined with each other.
module sbox_share_sched
  import sbox_share_sched_pkg::*;
#(
  parameter int SBOX_LAT = 4,  // 1..8
  parameter int RND_W    = 8,
  parameter int ST_BYTES = ST_BYTES_DEF,
  parameter int KS_BYTES = KS_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [7:0]           st_s0,
  input  logic [7:0]           st_s1,
  input  logic [ST_TAG_W-1:0]  st_tag,
  input  logic                 ks_valid,
  output logic                 ks_ready,
  input  logic [7:0]           ks_s0,
  input  logic [7:0]           ks_s1,
  input  logic [KS_TAG_W-1:0]  ks_tag,
  input  logic                 rnd_valid,
  input  logic [RND_W-1:0]     rnd,
  output logic                 rnd_take,
  output logic                 core_en,
  output logic [7:0]           core_s0,
  output logic [7:0]           core_s1,
  output logic [RND_W-1:0]     core_rnd,
  input  logic [7:0]           core_o0,
  input  logic [7:0]           core_o1,
  output logic                 res_valid,
  output logic                 res_dst,
  output logic [RES_TAG_W-1:0] res_tag,
  output logic [7:0]           res_s0,
  output logic [7:0]           res_s1,
  output logic                 st_done,
  output logic                 ks_done,
  output logic                 busy
);

  // ptr_reg names the requester that wins the next contention.
  logic                ptr_reg, ptr_next;
  logic                issue, grant_ks;
  inflight_t           in_entry, out_entry;
  logic                tail_valid, tail_dst;

  logic [ST_CNT_W-1:0] st_cnt_reg, st_cnt_next;
  logic [KS_CNT_W-1:0] ks_cnt_reg, ks_cnt_next;
  logic                st_done_reg, st_done_next;
  logic                ks_done_reg, ks_done_next;
  logic [7:0]          res_s0_reg, res_s1_reg;

  // Arbitration and issue. Nothing is issued while in reset so that every
  // output reads zero during reset.
  always_comb begin
    issue    = !rst && rnd_valid && (st_valid || ks_valid);
    grant_ks = ks_valid && (!st_valid || (ptr_reg == DST_KS));
    st_ready = 1'b0;
    ks_ready = 1'b0;
    rnd_take = 1'b0;
    core_en  = 1'b0;
    core_s0  = '0;
    core_s1  = '0;
    core_rnd = '0;
    in_entry = '0;
    ptr_next = ptr_reg;
    if (issue) begin
      core_en        = 1'b1;
      rnd_take       = 1'b1;
      core_rnd       = rnd;
      in_entry.valid = 1'b1;
      if (grant_ks) begin
        ks_ready     = 1'b1;
        core_s0      = ks_s0;
        core_s1      = ks_s1;
        in_entry.dst = DST_KS;
        in_entry.tag = ks_tag_ext(ks_tag);
        ptr_next     = DST_ST;
      end else begin
        st_ready     = 1'b1;
        core_s0      = st_s0;
        core_s1      = st_s1;
        in_entry.dst = DST_ST;
        in_entry.tag = st_tag;
        ptr_next     = DST_KS;
      end
    end
  end

  sbox_share_sched_tag_pipe #(
    .SBOX_LAT (SBOX_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_entry   (in_entry),
    .tail_valid (tail_valid),
    .tail_dst   (tail_dst),
    .out_entry  (out_entry),
    .busy       (busy)
  );

  // Pass counters advance on the tail so the done pulse is registered
  // alongside the result it belongs to.
  always_comb begin
    st_cnt_next  = st_cnt_reg;
    ks_cnt_next  = ks_cnt_reg;
    st_done_next = 1'b0;
    ks_done_next = 1'b0;
    if (tail_valid && (tail_dst == DST_ST)) begin
      if (st_cnt_reg == ST_CNT_W'(ST_BYTES - 1)) begin
        st_cnt_next  = '0;
        st_done_next = 1'b1;
      end else begin
        st_cnt_next = st_cnt_reg + 1'b1;
      end
    end
    if (tail_valid && (tail_dst == DST_KS)) begin
      if (ks_cnt_reg == KS_CNT_W'(KS_BYTES - 1)) begin
        ks_cnt_next  = '0;
        ks_done_next = 1'b1;
      end else begin
        ks_cnt_next = ks_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= DST_ST;
      st_cnt_reg  <= '0;
      ks_cnt_reg  <= '0;
      st_done_reg <= 1'b0;
      ks_done_reg <= 1'b0;
      res_s0_reg  <= '0;
      res_s1_reg  <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      st_cnt_reg  <= st_cnt_next;
      ks_cnt_reg  <= ks_cnt_next;
      st_done_reg <= st_done_next;
      ks_done_reg <= ks_done_next;
      // Idle cycles leave zeros on the result bus rather than stale shares.
      res_s0_reg  <= tail_valid ? core_o0 : '0;
      res_s1_reg  <= tail_valid ? core_o1 : '0;
    end
  end

  assign res_valid = out_entry.valid;
  assign res_dst   = out_entry.dst;
  assign res_tag   = out_entry.tag;
  assign res_s0    = res_s0_reg;
  assign res_s1    = res_s1_reg;
  assign st_done   = st_done_reg;
  assign ks_done   = ks_done_reg;

endmodule
